// File: rtl/sw_sample_ctrl_pkg.sv
// rtl/sw_sample_ctrl_pkg.sv - shared register map, bit indices and APB FSM encoding
package sw_sample_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_DBLIM  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int EN_BIT    = 0;
  localparam int IRQEN_BIT = 1;
  localparam int CHG_BIT   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } apb_state_e;

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch synchroniser, debounce counter and stable value register
module sw_debounce #(
  parameter int SW_W = 2,
  parameter int DB_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [DB_W-1:0] limit,
  input  logic [SW_W-1:0] raw,
  output logic [SW_W-1:0] stable,
  output logic            chg_pulse,
  output logic            busy
);

  logic [SW_W-1:0] r_meta;
  logic [SW_W-1:0] r_sync;
  logic [SW_W-1:0] r_stable;
  logic [DB_W-1:0] r_cnt;
  logic            r_chg_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta      <= '0;
      r_sync      <= '0;
      r_stable    <= '0;
      r_cnt       <= '0;
      r_chg_pulse <= 1'b0;
    end else begin
      r_meta      <= raw;
      r_sync      <= r_meta;
      r_chg_pulse <= 1'b0;
      if (!en || (r_sync == r_stable)) begin
        r_cnt <= '0;
      end else if (r_cnt >= limit) begin
        // >= so lowering the limit mid-count still terminates instead of wrapping
        r_stable    <= r_sync;
        r_cnt       <= '0;
        r_chg_pulse <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable    = r_stable;
  assign chg_pulse = r_chg_pulse;
  assign busy      = (r_cnt != '0);

endmodule

// File: rtl/sw_sample_ctrl.sv
// rtl/sw_sample_ctrl.sv - APB switch-port controller: wait-stated reads, registers, change IRQ
module sw_sample_ctrl
  import sw_sample_ctrl_pkg::*;
#(
  parameter int              SW_W       = 2,
  parameter int              DB_W       = 8,
  parameter logic [DB_W-1:0] DB_DEFAULT = DB_W'(50)
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [3:0]      PADDR,
  input  logic [7:0]      PWDATA,
  output logic [7:0]      PRDATA,
  output logic            PREADY,
  output logic            PSLVERR,
  input  logic [SW_W-1:0] SWCON,
  output logic            IRQ,
  output logic [4:0]      TPS
);

  apb_state_e      r_state;
  apb_state_e      w_next_state;
  logic [7:0]      r_prdata;
  logic [1:0]      r_ctrl;
  logic [DB_W-1:0] r_dblim;
  logic            r_chg;
  logic            r_irq;

  logic [SW_W-1:0] w_stable;
  logic            w_chg_pulse;
  logic            w_busy;
  logic [1:0]      w_reg_sel;
  logic            w_setup_rd;
  logic            w_access_wr;
  logic            w_wr_en;
  logic            w_ready;
  logic            w_rd_wait;
  logic [7:0]      w_rd_mux;
  logic            w_unused;

  assign w_reg_sel   = PADDR[3:2];
  assign w_setup_rd  = PSEL & ~PENABLE & ~PWRITE;
  assign w_access_wr = (r_state == IDLE) & PSEL & PENABLE & PWRITE;
  // DATA is read-only: a write there errors and commits nothing
  assign w_wr_en     = w_access_wr & (w_reg_sel != ADDR_DATA);
  assign w_unused    = &{1'b0, PADDR[1:0]};

  sw_debounce #(
    .SW_W (SW_W),
    .DB_W (DB_W)
  ) u_debounce (
    .clk       (PCLK),
    .reset     (PRESET),
    .en        (r_ctrl[EN_BIT]),
    .limit     (r_dblim),
    .raw       (SWCON),
    .stable    (w_stable),
    .chg_pulse (w_chg_pulse),
    .busy      (w_busy)
  );

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b1;
    w_rd_wait    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup_rd) w_next_state = RD_WAIT;
      end
      RD_WAIT: begin
        w_ready      = 1'b0;
        w_rd_wait    = 1'b1;
        w_next_state = RD_DONE;
      end
      RD_DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_reg_sel)
      ADDR_DATA:   w_rd_mux[SW_W-1:0] = w_stable;
      ADDR_CTRL:   w_rd_mux[1:0]      = r_ctrl;
      ADDR_DBLIM:  w_rd_mux[DB_W-1:0] = r_dblim;
      ADDR_STATUS: w_rd_mux[CHG_BIT]  = r_chg;
      default:     w_rd_mux           = '0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= IDLE;
      r_prdata <= '0;
      r_ctrl   <= '0;
      r_dblim  <= DB_DEFAULT;
      r_chg    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_rd_wait) r_prdata <= w_rd_mux;
      if (w_wr_en && (w_reg_sel == ADDR_CTRL))  r_ctrl  <= PWDATA[1:0];
      if (w_wr_en && (w_reg_sel == ADDR_DBLIM)) r_dblim <= PWDATA[DB_W-1:0];
      // a new change event beats a simultaneous write-1-to-clear
      if (w_chg_pulse) begin
        r_chg <= 1'b1;
      end else if (w_wr_en && (w_reg_sel == ADDR_STATUS) && PWDATA[CHG_BIT]) begin
        r_chg <= 1'b0;
      end
      r_irq <= r_chg & r_ctrl[IRQEN_BIT];
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = w_ready;
  assign PSLVERR = w_access_wr & (w_reg_sel == ADDR_DATA);
  assign IRQ     = r_irq;
  assign TPS     = {w_ready, w_busy, w_rd_wait, w_chg_pulse, r_irq};

endmodule

// File: tb/tb_sw_sample_ctrl.sv
// tb/tb_sw_sample_ctrl.sv - self-checking bench for sw_sample_ctrl
module tb_sw_sample_ctrl;

  logic       PCLK    = 1'b0;
  logic       PRESET  = 1'b1;
  logic       PSEL    = 1'b0;
  logic       PENABLE = 1'b0;
  logic       PWRITE  = 1'b0;
  logic [3:0] PADDR   = 4'h0;
  logic [7:0] PWDATA  = 8'h00;
  logic [1:0] SWCON   = 2'b00;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic       IRQ;
  logic [4:0] TPS;

  int n_checks = 0;
  int n_fail   = 0;

  sw_sample_ctrl dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .SWCON   (SWCON),
    .IRQ     (IRQ),
    .TPS     (TPS)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents plus the run length of a pending switch difference
  int m_s1, m_sync, m_stable, m_run, m_ctrl, m_dblim, m_chg, m_irq, m_prdata, m_phase;
  int m_pulse;
  bit m_valid = 1'b0;

  function automatic int reg_val(input int a);
    case (a)
      0:       return m_stable;
      1:       return m_ctrl;
      2:       return m_dblim;
      default: return m_chg;
    endcase
  endfunction

  always @(posedge PCLK) begin
    int a, n_stable, n_run, n_pulse, n_chg;
    bit wr;
    a  = int'(PADDR[3:2]);
    wr = (m_phase == 0) && PSEL && PENABLE && PWRITE;
    if (PRESET) begin
      m_s1 = 0; m_sync = 0; m_stable = 0; m_run = 0; m_pulse = 0;
      m_ctrl = 0; m_dblim = 50; m_chg = 0; m_irq = 0; m_prdata = 0; m_phase = 0;
      m_valid = 1'b1;
    end else begin
      n_stable = m_stable;
      n_run    = 0;
      n_pulse  = 0;
      if (((m_ctrl & 1) != 0) && (m_sync != m_stable)) begin
        if (m_run >= m_dblim) begin
          n_stable = m_sync;
          n_pulse  = 1;
        end else begin
          n_run = m_run + 1;
        end
      end
      if (m_pulse != 0) n_chg = 1;
      else if (wr && a == 3 && PWDATA[0]) n_chg = 0;
      else n_chg = m_chg;
      m_irq = ((m_chg != 0) && ((m_ctrl & 2) != 0)) ? 1 : 0;
      if (m_phase == 1) m_prdata = reg_val(a);
      if (wr && a == 1) m_ctrl = int'(PWDATA) & 3;
      if (wr && a == 2) m_dblim = int'(PWDATA);
      case (m_phase)
        0:       m_phase = (PSEL && !PENABLE && !PWRITE) ? 1 : 0;
        1:       m_phase = 2;
        default: m_phase = 0;
      endcase
      m_chg    = n_chg;
      m_stable = n_stable;
      m_run    = n_run;
      m_pulse  = n_pulse;
      m_sync   = m_s1;
      m_s1     = int'(SWCON);
    end
  end

  always @(negedge PCLK) begin
    int exp_err, exp_tps;
    if (m_valid) begin
      exp_err = ((m_phase == 0) && PSEL && PENABLE && PWRITE && PADDR[3:2] == 2'd0) ? 1 : 0;
      exp_tps = m_irq | (m_pulse << 1) | ((m_phase == 1 ? 1 : 0) << 2)
              | ((m_run != 0 ? 1 : 0) << 3) | ((m_phase != 1 ? 1 : 0) << 4);
      check("model_PREADY", int'(PREADY), (m_phase != 1) ? 1 : 0);
      check("model_PSLVERR", int'(PSLVERR), exp_err);
      check("model_PRDATA", int'(PRDATA), m_prdata);
      check("model_IRQ", int'(IRQ), m_irq);
      check("model_TPS", int'(TPS), exp_tps);
    end
  end

  task automatic apb_read(input logic [3:0] a, output int d, output int waits, output int err);
    bit done;
    d = 0; waits = 0; err = 0; done = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      if (PREADY) begin
        d = int'(PRDATA); err = int'(PSLVERR); done = 1'b1;
        break;
      end
      waits++;
      @(posedge PCLK); #1;
    end
    if (!done) check("rd_timeout", 0, 1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [7:0] d,
                           output int err, output int rdy, output logic [4:0] tps);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    err = int'(PSLVERR); rdy = int'(PREADY); tps = TPS;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge PCLK); #1;
      if (TPS[1]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d, w, e, r, n;
    logic [4:0] t;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // reset values over the bus
    apb_read(4'h8, d, w, e);
    check("rd_dblim_waits", w, 1);
    check("rd_dblim_reset", d, 50);
    check("rd_dblim_slverr", e, 0);
    apb_read(4'h4, d, w, e);
    check("rd_ctrl_reset", d, 0);

    // enable, limit 4, settle 00 -> 01
    apb_write(4'h4, 8'h03, e, r, t);
    check("wr_ctrl_ready", r, 1);
    check("wr_ctrl_slverr", e, 0);
    apb_write(4'h8, 8'h04, e, r, t);
    check("wr_dblim_ready", r, 1);
    @(posedge PCLK); #1 SWCON = 2'b01;
    wait_pulse(n);
    check("pulse_latency_lim4", n, 7);
    @(posedge PCLK); #1;
    check("irq_after_chg_set", int'(IRQ), 0);
    @(posedge PCLK); #1;
    check("irq_rises", int'(IRQ), 1);
    apb_read(4'h0, d, w, e);
    check("rd_data_01", d, 1);
    apb_read(4'hC, d, w, e);
    check("rd_status_set", d, 1);

    // clear collides with a new change event: set wins
    @(posedge PCLK); #1 SWCON = 2'b00;
    repeat (5) @(posedge PCLK);
    apb_write(4'hC, 8'h01, e, r, t);
    check("collide_pulse_seen", int'(t[1]), 1);
    apb_read(4'hC, d, w, e);
    check("rd_status_set_wins", d, 1);
    apb_read(4'h0, d, w, e);
    check("rd_data_00", d, 0);
    apb_write(4'hC, 8'h01, e, r, t);
    @(posedge PCLK); #1;
    check("irq_cleared", int'(IRQ), 0);
    apb_read(4'hC, d, w, e);
    check("rd_status_cleared", d, 0);

    // 3-cycle glitch below the limit
    @(posedge PCLK); #1 SWCON = 2'b01;
    repeat (3) @(posedge PCLK);
    #1 SWCON = 2'b00;
    @(posedge PCLK);
    @(posedge PCLK); #1;
    check("glitch_counting", int'(TPS[3]), 1);
    repeat (3) @(posedge PCLK);
    #1;
    check("glitch_counter_zero", int'(TPS[3]), 0);
    apb_read(4'h0, d, w, e);
    check("glitch_data", d, 0);
    apb_read(4'hC, d, w, e);
    check("glitch_status", d, 0);

    // write to read-only DATA, then legal writes
    apb_write(4'h0, 8'hFF, e, r, t);
    check("wr_data_slverr", e, 1);
    apb_read(4'h0, d, w, e);
    check("wr_data_no_effect", d, 0);
    apb_write(4'h4, 8'h03, e, r, t);
    check("wr_ctrl2_slverr", e, 0);
    apb_write(4'h8, 8'h00, e, r, t);
    check("wr_dblim0_slverr", e, 0);
    check("wr_dblim0_ready", r, 1);

    // limit 0: stable follows on the first differing cycle
    @(posedge PCLK); #1 SWCON = 2'b10;
    wait_pulse(n);
    check("pulse_latency_lim0", n, 3);
    apb_read(4'h0, d, w, e);
    check("rd_data_10", d, 2);

    // reset while the read is stalled
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h4;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(negedge PCLK);
    check("rst_in_rd_wait_stall", int'(PREADY), 0);
    @(posedge PCLK); #1;
    check("rst_pready", int'(PREADY), 1);
    check("rst_fsm_idle", int'(TPS[2]), 0);
    check("rst_irq", int'(IRQ), 0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    apb_read(4'h4, d, w, e);
    check("rst_ctrl", d, 0);
    apb_read(4'h8, d, w, e);
    check("rst_dblim", d, 50);

    repeat (2) @(posedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
